// File: rtl/fetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, issues one word read at a time
// to instruction memory and buffers returned instructions in a first-word-fall-through FIFO.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       inst_valid,
    output logic [31:0]                inst,
    output logic [31:0]                inst_pc,
    output logic [31:0]                inst_pcplus4,
    input  logic                       inst_ready,
    output logic [$clog2(DEPTH):0]     count
);
    // state | meaning
    // IDLE  | no request outstanding; start one when space exists and no redirect
    // WAIT  | request to fetch_pc outstanding; response is pushed on ack
    // DROP  | request outstanding for a flushed address; response is discarded

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t          state;
    logic [31:0]     fetch_pc;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [31:0]     pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic            push;
    logic            pop;
    logic [CW-1:0]   count_next;
    logic [31:0]     redirect_aligned;
    logic            unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];
    assign redirect_aligned     = {redirect_pc[31:2], 2'b00};

    assign inst_valid   = (count != '0);
    assign inst         = inst_valid ? instr_mem[rd_ptr] : '0;
    assign inst_pc      = inst_valid ? pc_mem[rd_ptr] : '0;
    assign inst_pcplus4 = inst_valid ? (pc_mem[rd_ptr] + 32'd4) : '0;

    assign pop  = inst_valid && inst_ready && !redirect;
    assign push = (state == WAIT) && imem_ack && !redirect;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    // Storage is not reset; head outputs are gated by inst_valid instead.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= imem_addr;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count <= count_next;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            if (redirect) begin
                fetch_pc <= redirect_aligned;
            end else if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            case (state)
                IDLE: begin
                    if (!redirect && (count < DEPTH_C)) begin
                        state     <= WAIT;
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        // The outstanding request cannot be withdrawn; drain it in DROP.
                        if (imem_ack) begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end else begin
                            state <= DROP;
                        end
                    end else if (imem_ack) begin
                        if (count_next < DEPTH_C) begin
                            imem_addr <= fetch_pc + 32'd4;
                        end else begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stimulus pushes expected fetches into a scoreboard,
// a monitor pops and compares whenever the consumer accepts an instruction.
module tb_fetch_queue;
    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pcplus4;
    logic        inst_ready;
    logic [2:0]  count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_pops  = 0;
    int          n_acks  = 0;
    logic [31:0] last_ack_addr = '0;
    int          mem_lat = 0;
    int          wait_cnt = 0;
    logic        stray_ack = 1'b0;
    logic        pend = 1'b0;
    logic        pend_rst = 1'b1;
    logic [31:0] pend_addr = '0;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst(inst),
        .inst_pc(inst_pc),
        .inst_pcplus4(inst_pcplus4),
        .inst_ready(inst_ready),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: ack after mem_lat wait cycles, data = word index of the address.
    assign imem_ack   = (imem_req && (wait_cnt >= mem_lat)) || stray_ack;
    assign imem_rdata = imem_addr >> 2;

    always @(posedge clk) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (pend && !pend_rst) begin
            check("req_held", 32'(imem_req), 32'd1);
            check("addr_held", imem_addr, pend_addr);
        end
        pend      = imem_req && !imem_ack;
        pend_addr = imem_addr;
        pend_rst  = reset;

        if (!reset && imem_req && imem_ack) begin
            n_acks++;
            last_ack_addr = imem_addr;
        end

        if (!reset && inst_valid && inst_ready && !redirect) begin
            n_pops++;
            if (sb.size() == 0) begin
                check("unexpected_pop_pc", inst_pc, 32'hDEAD_BEEF);
            end else begin
                e = sb.pop_front();
                check("inst_pc", inst_pc, e.pc);
                check("inst", inst, e.instr);
                check("inst_pcplus4", inst_pcplus4, e.pc + 32'd4);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        logic [31:0] pc;
        for (int i = 0; i < n; i++) begin
            pc = start + 32'(4 * i);
            sb.push_back('{pc: pc, instr: pc >> 2});
        end
    endtask

    task automatic wait_pops(input int n, input int limit);
        int target;
        target = n_pops + n;
        for (int i = 0; i < limit; i++) begin
            if (n_pops >= target) break;
            cyc(1);
        end
        check("pops_reached", 32'(n_pops >= target), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 32'(imem_req), 32'd0);
        check({tag, "_addr"}, imem_addr, 32'h0);
        check({tag, "_valid"}, 32'(inst_valid), 32'd0);
        check({tag, "_inst"}, inst, 32'h0);
        check({tag, "_inst_pc"}, inst_pc, 32'h0);
        check({tag, "_pcplus4"}, inst_pcplus4, 32'h0);
        check({tag, "_count"}, 32'(count), 32'd0);
    endtask

    initial begin
        int  base;
        int  acks0;
        bit  found;

        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1; mem_lat = 0;

        // Reset, then zero-wait streaming from RESET_PC.
        push_seq(32'h0, 20);
        cyc(2);
        check_reset_outputs("rst1");
        reset = 1'b0;
        cyc(1);
        check("r2_req", 32'(imem_req), 32'd1);
        check("r2_addr", imem_addr, 32'h0);
        check("r2_valid", 32'(inst_valid), 32'd0);
        cyc(1);
        check("r3_valid", 32'(inst_valid), 32'd1);
        check("r3_pc", inst_pc, 32'h0);
        base = n_pops;
        cyc(8);
        check("throughput", 32'(n_pops - base), 32'd8);

        // Backpressure: fill to DEPTH, then a single pop lets exactly one more fetch through.
        reset = 1'b1; inst_ready = 1'b0;
        sb.delete();
        push_seq(32'h0, 20);
        cyc(2);
        reset = 1'b0;
        acks0 = n_acks;
        cyc(10);
        check("bp_pushes", 32'(n_acks - acks0), 32'd4);
        check("bp_count", 32'(count), 32'd4);
        check("bp_req", 32'(imem_req), 32'd0);
        check("bp_head", inst_pc, 32'h0);
        inst_ready = 1'b1;
        cyc(1);
        inst_ready = 1'b0;
        cyc(8);
        check("bp_pushes2", 32'(n_acks - acks0), 32'd5);
        check("bp_last_addr", last_ack_addr, 32'd16);
        check("bp_count2", 32'(count), 32'd4);
        check("bp_req2", 32'(imem_req), 32'd0);
        check("bp_head2", inst_pc, 32'd4);

        // Redirect while idle and full, then redirect in WAIT with 3-cycle memory.
        mem_lat = 3;
        sb.delete();
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        cyc(1);
        redirect = 1'b0;
        check("ri_count", 32'(count), 32'd0);
        check("ri_valid", 32'(inst_valid), 32'd0);
        cyc(1);
        check("ri_req", 32'(imem_req), 32'd1);
        check("ri_addr", imem_addr, 32'h0000_0200);
        cyc(1);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        cyc(1);
        redirect = 1'b0;
        check("drop_req", 32'(imem_req), 32'd1);
        check("drop_addr", imem_addr, 32'h0000_0200);
        check("drop_count", 32'(count), 32'd0);
        cyc(1);
        check("drop_addr2", imem_addr, 32'h0000_0200);
        cyc(1);
        check("drop_idle_req", 32'(imem_req), 32'd0);
        inst_ready = 1'b1;
        push_seq(32'h0000_0100, 20);
        cyc(1);
        check("newreq_req", 32'(imem_req), 32'd1);
        check("newreq_addr", imem_addr, 32'h0000_0100);
        wait_pops(2, 40);

        // Redirect coinciding with ack and a pending pop.
        mem_lat = 0;
        cyc(6);
        redirect = 1'b1; redirect_pc = 32'h0000_0300;
        sb.delete();
        push_seq(32'h0000_0300, 20);
        cyc(1);
        redirect = 1'b0;
        check("ra_count", 32'(count), 32'd0);
        check("ra_valid", 32'(inst_valid), 32'd0);
        check("ra_req", 32'(imem_req), 32'd0);
        cyc(1);
        check("ra_req2", 32'(imem_req), 32'd1);
        check("ra_addr", imem_addr, 32'h0000_0300);
        wait_pops(3, 20);

        // Address wrap at the top of the 32-bit space; low bits of redirect_pc ignored.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF9;
        sb.delete();
        push_seq(32'hFFFF_FFF8, 20);
        cyc(1);
        redirect = 1'b0;
        cyc(1);
        check("wrap_addr", imem_addr, 32'hFFFF_FFF8);
        wait_pops(3, 20);

        // Reset while in DROP with the ack arriving during reset, then a stray ack while idle.
        inst_ready = 1'b0; mem_lat = 3;
        redirect = 1'b1; redirect_pc = 32'h0000_0500;
        sb.delete();
        cyc(1);
        redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req && imem_addr == 32'h0000_0500) begin
                found = 1'b1;
                break;
            end
            cyc(1);
        end
        check("d6_req_seen", 32'(found), 32'd1);
        cyc(1);
        redirect = 1'b1; redirect_pc = 32'h0000_0600;
        cyc(1);
        redirect = 1'b0;
        check("d6_drop_addr", imem_addr, 32'h0000_0500);
        reset = 1'b1; mem_lat = 0;
        sb.delete();
        cyc(1);
        check_reset_outputs("rst_drop");
        reset = 1'b0; stray_ack = 1'b1;
        push_seq(32'h0, 20);
        cyc(1);
        stray_ack = 1'b0;
        check("stray_count", 32'(count), 32'd0);
        check("stray_valid", 32'(inst_valid), 32'd0);
        check("restart_req", 32'(imem_req), 32'd1);
        check("restart_addr", imem_addr, 32'h0);
        inst_ready = 1'b1;
        wait_pops(3, 20);
        inst_ready = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front-end for the MIPS core. It owns the fetch PC, issues word reads to instruction memory over a req/ack handshake, and buffers returned instructions in a small FIFO. Decode and execute consume entries through a valid/ready interface. It is the stage directly upstream of the processor datapath. Branch, jump and jr resolution drive a redirect that flushes the queue and restarts fetch.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: fetch address after reset.

- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  word address of the request; bits [1:0] always 0.
- imem_ack  in  1  memory has returned data for the current request this cycle.
- imem_rdata  in  32  instruction word; sampled only when imem_req && imem_ack.
- redirect  in  1  control-flow change; flush and refetch.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0).
- inst_valid  out  1  queue head holds an instruction.
- inst  out  32  head instruction.
- inst_pc  out  32  address of head instruction.
- inst_pcplus4  out  32  inst_pc + 4, modulo 2^32 (link value for jal).
- inst_ready  in  1  consumer accepts head this cycle.
- count  out  $clog2(DEPTH)+1  number of valid entries.

## Operation
- Storage: DEPTH entries of {pc[31:0], instr[31:0]}, circular buffer with rd/wr pointers and count. Head outputs are first-word-fall-through: driven from the head entry, not registered separately.
- Pop: inst_valid && inst_ready && !redirect.
- Push: imem_req && imem_ack, in state WAIT only. The push writes {imem_addr, imem_rdata}, and fetch_pc becomes fetch_pc + 4.
- fetch_pc wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- FSM states:
  - IDLE: imem_req=0. Go to WAIT if count < DEPTH and !redirect.
  - WAIT: imem_req=1, imem_addr=fetch_pc. The address is held stable until ack. On ack, push. Stay in WAIT at the next address if (count + 1 − pop) < DEPTH and !redirect; otherwise go to IDLE.
  - DROP: imem_req=1, imem_addr held at the old address. The response is discarded. On ack, go to IDLE.
- A request is never withdrawn once imem_req has risen. At most one request is outstanding.
- Redirect, any state:
  - Queue is emptied next cycle (count=0, pointers reset).
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - Pop is suppressed.
  - In WAIT without ack in the same cycle: go to DROP.
  - In WAIT with ack in the same cycle: the data is discarded (no push), go to IDLE.
  - In DROP: stay in DROP until ack. The latest redirect_pc wins.
- Push and pop in the same cycle: count unchanged. Overflow is impossible because a request only starts or continues when space is reserved.
- Pop when empty is ignored. inst_ready is don't-care when !inst_valid.

## Timing
- Reset (any cycle, including mid-request or in DROP):
  - State = IDLE; count = 0; pointers = 0; fetch_pc = RESET_PC.
  - imem_req = 0; imem_addr = RESET_PC; inst_valid = 0; inst = 0; inst_pc = 0; inst_pcplus4 = 0.
  - A memory ack arriving after reset while in IDLE is ignored.
- Cycle R+1 after reset deasserts: IDLE, moves to WAIT.
- Cycle R+2: imem_req=1, imem_addr=RESET_PC.
- Zero-wait memory (ack in the same cycle as req): inst_valid=1 at R+3. Thereafter one instruction per cycle streams while the consumer keeps up.
- Ack-to-valid latency is 1 cycle. Redirect-to-new-req latency is 2 cycles, plus memory wait if in DROP.
- With a continuously ready consumer and zero-wait memory, throughput is 1 instr/cycle.

## Test plan
- Reset, RESET_PC=0, zero-wait memory returning addr>>2, inst_ready=1:
  - imem_req rises at R+2.
  - inst_valid at R+3 with inst_pc = 0, 4, 8, … consecutive, and inst_pcplus4 = inst_pc + 4.
- Backpressure: inst_ready=0, DEPTH=4:
  - Exactly 4 pushes, then imem_req=0 and count=4.
  - Raising inst_ready for one cycle pops pc 0, and exactly one new request, for pc 16, follows.
- Redirect in WAIT with 3-cycle memory latency: redirect=1, redirect_pc=32'h0000_0103 one cycle after req rises.
  - State goes to DROP and imem_addr stays at the old value until ack.
  - That data never appears on inst.
  - The next request has addr 32'h0000_0100, and count=0 the cycle after redirect.
- Redirect and imem_ack in the same cycle with pop pending:
  - No push, no pop, count=0 next cycle.
  - Next request to redirect_pc.
- Wrap: redirect_pc=32'hFFFF_FFF8, stream 3 instructions.
  - inst_pc = FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - inst_pcplus4 at FFFF_FFFC is 0.
- Reset asserted while in DROP with a pending ack:
  - All outputs return to their reset values.
  - The stale ack is not pushed.
  - Fetch restarts at RESET_PC.
